// File: rtl/rtcalarm_bank_if.sv
// Bus-side signal bundle for the RTC alarm bank: time input, channel write/select, readback and alarms.
interface rtcalarm_bank_if #(
  parameter int NCH = 4,
  parameter int AW  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [21:0]    i_now;
  logic           i_wr;
  logic [AW-1:0]  i_addr;
  logic [21:0]    i_alarm_time;
  logic [2:0]     i_valid;
  logic           i_enable;
  logic           i_oneshot;
  logic           i_clear;
  logic           i_snooze;
  logic [31:0]    o_data;
  logic [NCH-1:0] o_alarm;
  logic           o_int;

  modport slave (
    input  i_now, i_wr, i_addr, i_alarm_time, i_valid,
           i_enable, i_oneshot, i_clear, i_snooze,
    output o_data, o_alarm, o_int
  );

  modport master (
    output i_now, i_wr, i_addr, i_alarm_time, i_valid,
           i_enable, i_oneshot, i_clear, i_snooze,
    input  o_data, o_alarm, o_int
  );
endinterface

// File: rtl/rtcalarm_bank.sv
// Bank of NCH daily BCD alarms with one-shot mode, per-channel snooze timer and a combined interrupt.
module rtcalarm_bank #(
  parameter int          NCH            = 4,
  parameter int          AW             = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int          SNOOZE_SECONDS = 300,
  parameter logic [21:0] INITIAL_TIME   = 22'h0,
  parameter logic        START_ENABLED  = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  rtcalarm_bank_if.slave bus
);
  localparam int CW = $clog2(SNOOZE_SECONDS + 1);

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v <= max) && (v[3:0] <= 4'd9);
  endfunction

  logic [21:0]          past_time;
  logic                 sec_tick;
  logic                 addr_ok;
  logic [2:0]           field_ok;
  logic [2:0]           pre_valid;
  logic [21:0]          pre_data;
  logic [AW-1:0]        pre_addr;
  logic [NCH-1:0]       tripped, snoozing, enabled, oneshot;
  logic [NCH-1:0][21:0] alarm;
  logic [31:0]          rd_data;

  assign sec_tick = (bus.i_now != past_time);
  assign addr_ok  = ({{(32-AW){1'b0}}, bus.i_addr} < 32'(NCH));
  assign field_ok = {bcd_ok({2'b00, bus.i_alarm_time[21:16]}, 8'h23),
                     bcd_ok(bus.i_alarm_time[15:8], 8'h59),
                     bcd_ok(bus.i_alarm_time[7:0], 8'h59)};

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NCH; k++)
      if (bus.i_addr == AW'(k))
        rd_data = {4'h0, oneshot[k], snoozing[k], tripped[k], enabled[k], 2'b00, alarm[k]};
  end

  // Stage 1 of the alarm-time write; only BCD-legal, selected fields survive.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      past_time  <= '0;
      pre_valid  <= '0;
      pre_data   <= '0;
      pre_addr   <= '0;
      bus.o_data <= '0;
      bus.o_int  <= 1'b0;
    end else begin
      past_time  <= bus.i_now;
      pre_valid  <= {3{bus.i_wr & addr_ok}} & bus.i_valid & field_ok;
      pre_data   <= bus.i_alarm_time;
      pre_addr   <= bus.i_addr;
      bus.o_data <= rd_data;
      bus.o_int  <= |tripped;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic          wr;
    logic          trip_r, snz_r, en_r, os_r;
    logic [CW-1:0] cnt;
    logic [21:0]   alm_r;

    assign wr = bus.i_wr && (bus.i_addr == AW'(k));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        trip_r <= 1'b0;
        snz_r  <= 1'b0;
        cnt    <= '0;
        os_r   <= 1'b0;
        en_r   <= START_ENABLED;
        alm_r  <= INITIAL_TIME;
      end else begin
        if (wr) begin
          en_r <= bus.i_enable;
          os_r <= bus.i_oneshot;
        end
        // A match wins over everything, including a same-cycle clear or enable write.
        if (en_r && sec_tick && (bus.i_now == alm_r)) begin
          trip_r <= 1'b1;
          if (os_r) en_r <= 1'b0;
        end else if (snz_r && sec_tick && (cnt == CW'(1))) begin
          trip_r <= 1'b1;
          snz_r  <= 1'b0;
          cnt    <= '0;
        end else if (wr && bus.i_clear) begin
          trip_r <= 1'b0;
          snz_r  <= 1'b0;
        end else if (wr && bus.i_snooze && trip_r) begin
          trip_r <= 1'b0;
          snz_r  <= 1'b1;
          cnt    <= CW'(SNOOZE_SECONDS);
        end else if (snz_r && sec_tick && (cnt != '0)) begin
          cnt <= cnt - CW'(1);
        end
        if (wr && !bus.i_enable) snz_r <= 1'b0;
        if (pre_addr == AW'(k)) begin
          if (pre_valid[2]) alm_r[21:16] <= pre_data[21:16];
          if (pre_valid[1]) alm_r[15:8]  <= pre_data[15:8];
          if (pre_valid[0]) alm_r[7:0]   <= pre_data[7:0];
        end
      end
    end

    assign tripped[k]  = trip_r;
    assign snoozing[k] = snz_r;
    assign enabled[k]  = en_r;
    assign oneshot[k]  = os_r;
    assign alarm[k]    = alm_r;
  end

  assign bus.o_alarm = tripped;
endmodule

// File: tb/tb_rtcalarm_bank.sv
// Directed bench for rtcalarm_bank: field-write table plus trip, one-shot, snooze, clear-race and reset sequences.
module tb_rtcalarm_bank;
  localparam int NCH = 5;
  localparam int AW  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rtcalarm_bank_if #(.NCH(NCH), .AW(AW)) bus();

  rtcalarm_bank #(
    .NCH(NCH), .AW(AW), .SNOOZE_SECONDS(3),
    .INITIAL_TIME(22'h0), .START_ENABLED(1'b0)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
  );

  typedef struct {
    int          ch;
    logic [21:0] t;
    logic [2:0]  v;
    logic        en;
    logic        os;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_wr(input int ch, input logic [21:0] t, input logic [2:0] v,
                       input logic en, input logic os, input logic clr, input logic snz);
    bus.i_wr = 1'b1;
    bus.i_addr = AW'(ch);
    bus.i_alarm_time = t;
    bus.i_valid = v;
    bus.i_enable = en;
    bus.i_oneshot = os;
    bus.i_clear = clr;
    bus.i_snooze = snz;
    tick();
    bus.i_wr = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_snooze = 1'b0;
    bus.i_valid = 3'b000;
  endtask

  task automatic rd(input int ch, output logic [31:0] d);
    bus.i_addr = AW'(ch);
    tick();
    d = bus.o_data;
  endtask

  task automatic set_now(input logic [21:0] t);
    bus.i_now = t;
    tick();
  endtask

  logic [31:0] d;

  initial begin
    tbl[0]  = '{2, 22'h07_30_00, 3'b111, 1'b1, 1'b0, 32'h0107_3000};
    tbl[1]  = '{0, 22'h25_61_0A, 3'b111, 1'b0, 1'b0, 32'h0000_0000};
    tbl[2]  = '{0, 22'h00_00_45, 3'b001, 1'b0, 1'b0, 32'h0000_0045};
    tbl[3]  = '{0, 22'h12_34_56, 3'b010, 1'b1, 1'b0, 32'h0100_3445};
    tbl[4]  = '{0, 22'h23_59_59, 3'b100, 1'b1, 1'b1, 32'h0923_3445};
    tbl[5]  = '{1, 22'h24_5A_60, 3'b111, 1'b0, 1'b0, 32'h0000_0000};
    tbl[6]  = '{1, 22'h19_09_59, 3'b111, 1'b0, 1'b0, 32'h0019_0959};
    tbl[7]  = '{1, 22'h1A_00_00, 3'b100, 1'b0, 1'b0, 32'h0019_0959};
    tbl[8]  = '{5, 22'h01_01_01, 3'b111, 1'b1, 1'b0, 32'h0000_0000};
    tbl[9]  = '{4, 22'h00_00_09, 3'b001, 1'b1, 1'b0, 32'h0100_0009};
    tbl[10] = '{3, 22'h00_00_00, 3'b000, 1'b1, 1'b1, 32'h0900_0000};

    bus.i_now = '0; bus.i_wr = 1'b0; bus.i_addr = '0; bus.i_alarm_time = '0;
    bus.i_valid = '0; bus.i_enable = 1'b0; bus.i_oneshot = 1'b0;
    bus.i_clear = 1'b0; bus.i_snooze = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_data", bus.o_data, 32'h0);
    check("rst_alarm", 32'(bus.o_alarm), 32'h0);
    check("rst_int", 32'(bus.o_int), 32'h0);
    rst_n = 1'b1;
    rd(0, d);
    check("post_rst_rd0", d, 32'h0);

    // Field writes and BCD filtering
    for (int i = 0; i < 11; i++) begin
      do_wr(tbl[i].ch, tbl[i].t, tbl[i].v, tbl[i].en, tbl[i].os, 1'b0, 1'b0);
      tick();
      rd(tbl[i].ch, d);
      check($sformatf("tbl%0d", i), d, tbl[i].exp);
    end
    check("tbl_no_alarm", 32'(bus.o_alarm), 32'h0);
    for (int c = 0; c < NCH; c++)
      if (c != 2) do_wr(c, 22'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // T1: ch2 trips one clock after i_now reaches 07:30:00, interrupt one later
    set_now(22'h07_29_59);
    tick();
    check("t1_pre", 32'(bus.o_alarm), 32'h0);
    set_now(22'h07_30_00);
    check("t1_alarm", 32'(bus.o_alarm), 32'h04);
    check("t1_int_lag", 32'(bus.o_int), 32'h0);
    tick();
    check("t1_int", 32'(bus.o_int), 32'h1);
    rd(2, d);
    check("t1_rd", d, 32'h0307_3000);
    do_wr(2, 22'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_clear", 32'(bus.o_alarm), 32'h0);

    // T3: one-shot disables itself after tripping
    do_wr(1, 22'h12_00_00, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_now(22'h11_59_59);
    set_now(22'h12_00_00);
    check("t3_trip", 32'(bus.o_alarm), 32'h02);
    rd(1, d);
    check("t3_rd", d, 32'h0A12_0000);
    do_wr(1, 22'h0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    set_now(22'h11_59_59);
    set_now(22'h12_00_00);
    tick();
    check("t3_no_retrip", 32'(bus.o_alarm), 32'h0);
    rd(1, d);
    check("t3_rd2", d, 32'h0812_0000);

    // T4: snooze of 3 seconds
    do_wr(3, 22'h06_00_00, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_now(22'h05_59_59);
    set_now(22'h06_00_00);
    check("t4_trip", 32'(bus.o_alarm), 32'h08);
    do_wr(3, 22'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    rd(3, d);
    check("t4_snoozing", d, 32'h0506_0000);
    set_now(22'h06_00_01);
    set_now(22'h06_00_02);
    check("t4_not_yet", 32'(bus.o_alarm), 32'h0);
    set_now(22'h06_00_03);
    check("t4_expire", 32'(bus.o_alarm), 32'h08);
    rd(3, d);
    check("t4_rd_exp", d, 32'h0306_0000);
    do_wr(3, 22'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_wr(3, 22'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    rd(3, d);
    check("t4_snz_ignored", d, 32'h0106_0000);
    set_now(22'h06_00_04);
    set_now(22'h06_00_05);
    set_now(22'h06_00_06);
    check("t4_quiet", 32'(bus.o_alarm), 32'h0);

    // T5: match beats a same-cycle clear, held time does not retrip
    do_wr(0, 22'h08_00_00, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_now(22'h07_59_59);
    bus.i_now = 22'h08_00_00;
    do_wr(0, 22'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t5_match_wins", 32'(bus.o_alarm), 32'h01);
    do_wr(0, 22'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (10) tick();
    check("t5_no_retrip", 32'(bus.o_alarm), 32'h0);

    // T6: reset mid-snooze and mid-write
    set_now(22'h05_59_59);
    set_now(22'h06_00_00);
    check("t6_trip3", 32'(bus.o_alarm), 32'h08);
    do_wr(3, 22'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    set_now(22'h08_00_00);
    check("t6_trip0", 32'(bus.o_alarm), 32'h01);
    tick();
    check("t6_int", 32'(bus.o_int), 32'h1);
    bus.i_addr = 3'd0;
    do_wr(4, 22'h09_09_09, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_alarm", 32'(bus.o_alarm), 32'h0);
    check("t6_rst_int", 32'(bus.o_int), 32'h0);
    check("t6_rst_data", bus.o_data, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    rd(4, d);
    check("t6_no_late_wr", d, 32'h0);
    rd(3, d);
    check("t6_snz_gone", d, 32'h0);
    set_now(22'h08_00_01);
    set_now(22'h08_00_02);
    set_now(22'h08_00_03);
    set_now(22'h08_00_04);
    check("t6_quiet", 32'(bus.o_alarm), 32'h0);
    check("t6_int_quiet", 32'(bus.o_int), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
